// File: rtl/time_set_ctrl.sv
// Front-panel key debounce, RUN/SET_MIN/SET_HOUR mode FSM, CH single/auto-repeat pulses, idle timeout, blink.
// Latency: CH/STATE update one CP after a key event (event = cycle after debounced rise); no backpressure.
module time_set_ctrl #(
  parameter int DEB_TICKS     = 20,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100,
  parameter int TIMEOUT_TICKS = 10000,
  parameter int BLINK_HALF    = 250
) (
  input  logic       CP,
  input  logic       RST,
  input  logic       TICK,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  output logic       ADJMODE,
  output logic       SELMODE,
  output logic       CH,
  output logic       BLINK,
  output logic [1:0] STATE
);
  localparam int DW   = $clog2(DEB_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int IW   = $clog2(TIMEOUT_TICKS + 1);
  localparam int BW   = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {S_RUN = 2'b00, S_MIN = 2'b01, S_HOUR = 2'b10} state_e;

  // Key index 0 is MODE, 1 is INC.
  logic [1:0]    sync1_q, sync2_q, deb_q, deb_d, debp_q;
  logic [DW-1:0] dcnt_q [2];
  logic [DW-1:0] dcnt_d [2];
  state_e        state_q, state_d;
  logic          rep_act_q, rep_act_d, rep_fired_q, rep_fired_d;
  logic [RW-1:0] rcnt_q, rcnt_d, rep_target;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          ch_q, ch_d, blink_q, blink_d, adj_q, sel_q;
  logic          mode_ev, inc_ev, in_set, rep_hit, ch_trig, timeout;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      deb_d[k]  = deb_q[k];
      dcnt_d[k] = dcnt_q[k];
      if (sync2_q[k] == deb_q[k]) begin
        dcnt_d[k] = '0;
      end else if (TICK) begin
        if (dcnt_q[k] + 1'b1 == DW'(DEB_TICKS)) begin
          deb_d[k]  = ~deb_q[k];
          dcnt_d[k] = '0;
        end else begin
          dcnt_d[k] = dcnt_q[k] + 1'b1;
        end
      end
    end
  end

  assign mode_ev    = deb_q[0] & ~debp_q[0];
  assign inc_ev     = deb_q[1] & ~debp_q[1];
  assign in_set     = (state_q != S_RUN);
  assign rep_target = rep_fired_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY);
  assign rep_hit    = TICK & rep_act_q & deb_q[1] & (rcnt_q + 1'b1 == rep_target);
  // MODE has priority over INC/repeat; a CH cycle counts as activity, so it also beats timeout.
  assign ch_trig    = in_set & ~mode_ev & (inc_ev | rep_hit);
  assign timeout    = in_set & ~mode_ev & ~ch_trig & TICK & (idle_q + 1'b1 == IW'(TIMEOUT_TICKS));

  always_comb begin
    state_d = state_q;
    if (mode_ev) begin
      case (state_q)
        S_RUN:   state_d = S_MIN;
        S_MIN:   state_d = S_HOUR;
        default: state_d = S_RUN;
      endcase
    end else if (timeout) begin
      state_d = S_RUN;
    end
  end

  always_comb begin
    ch_d        = ch_trig & ~ch_q;
    rep_act_d   = rep_act_q;
    rep_fired_d = rep_fired_q;
    rcnt_d      = rcnt_q;
    // Repeat is armed only by a press seen inside a SET state.
    if (!in_set || mode_ev || !deb_q[1] || state_d != state_q) begin
      rep_act_d   = 1'b0;
      rep_fired_d = 1'b0;
      rcnt_d      = '0;
    end else if (inc_ev) begin
      rep_act_d   = 1'b1;
      rep_fired_d = 1'b0;
      rcnt_d      = '0;
    end else if (rep_act_q && TICK) begin
      if (rep_hit) begin
        rcnt_d      = '0;
        rep_fired_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end

    idle_d = idle_q;
    if (!in_set || mode_ev || ch_trig || timeout) idle_d = '0;
    else if (TICK)                                idle_d = idle_q + 1'b1;

    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (state_d == S_RUN || state_d != state_q || ch_d) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (TICK) begin
      if (bcnt_q + 1'b1 == BW'(BLINK_HALF)) begin
        blink_d = ~blink_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      debp_q      <= '0;
      dcnt_q[0]   <= '0;
      dcnt_q[1]   <= '0;
      state_q     <= S_RUN;
      rep_act_q   <= 1'b0;
      rep_fired_q <= 1'b0;
      rcnt_q      <= '0;
      idle_q      <= '0;
      bcnt_q      <= '0;
      ch_q        <= 1'b0;
      blink_q     <= 1'b1;
      adj_q       <= 1'b0;
      sel_q       <= 1'b0;
    end else begin
      sync1_q     <= {KEY_INC, KEY_MODE};
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      debp_q      <= deb_q;
      dcnt_q[0]   <= dcnt_d[0];
      dcnt_q[1]   <= dcnt_d[1];
      state_q     <= state_d;
      rep_act_q   <= rep_act_d;
      rep_fired_q <= rep_fired_d;
      rcnt_q      <= rcnt_d;
      idle_q      <= idle_d;
      bcnt_q      <= bcnt_d;
      ch_q        <= ch_d;
      blink_q     <= blink_d;
      adj_q       <= (state_d != S_RUN);
      sel_q       <= (state_d == S_HOUR);
    end
  end

  assign ADJMODE = adj_q;
  assign SELMODE = sel_q;
  assign CH      = ch_q;
  assign BLINK   = blink_q;
  assign STATE   = state_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed front-panel scenarios plus random key activity,
// compared every cycle against a tick-timestamp reference model.
module tb_time_set_ctrl;
  localparam int DEB = 2, RD = 5, RP = 3, TO = 20, BH = 4;

  logic       CP = 1'b0;
  logic       RST, TICK, KEY_MODE, KEY_INC;
  logic       ADJMODE, SELMODE, CH, BLINK;
  logic [1:0] STATE;

  time_set_ctrl #(
    .DEB_TICKS(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .TIMEOUT_TICKS(TO), .BLINK_HALF(BH)
  ) dut (
    .CP(CP), .RST(RST), .TICK(TICK), .KEY_MODE(KEY_MODE), .KEY_INC(KEY_INC),
    .ADJMODE(ADJMODE), .SELMODE(SELMODE), .CH(CH), .BLINK(BLINK), .STATE(STATE)
  );

  always #5 CP = ~CP;

  int errors = 0, checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: keys as sampled pipelines, timing as tick timestamps.
  bit [1:0] m_s1, m_s2, m_deb, m_debp;
  int       m_diff [2];
  int       m_state;
  bit       m_ch, m_blink = 1'b1, rep_on;
  int       tick_no, idle_ref, press_ref, blink_ref;

  function automatic bit rep_due(input int n);
    return (n == RD) || (n > RD && ((n - RD) % RP) == 0);
  endfunction

  task automatic model_step();
    int tn, st_n;
    bit mev, iev, rep, insets, ch_n;
    if (RST) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_debp = '0;
      m_diff[0] = 0; m_diff[1] = 0;
      m_state = 0; m_ch = 1'b0; m_blink = 1'b1; rep_on = 1'b0;
      return;
    end
    tn     = tick_no + int'(TICK);
    mev    = m_deb[0] & ~m_debp[0];
    iev    = m_deb[1] & ~m_debp[1];
    insets = (m_state != 0);
    rep    = insets && rep_on && m_deb[1] && TICK && rep_due(tn - press_ref);
    st_n   = m_state;
    ch_n   = 1'b0;
    if (mev) begin
      st_n = (m_state + 1) % 3;
      idle_ref = tn;
      rep_on = 1'b0;
    end else if (insets && (iev || rep)) begin
      ch_n = 1'b1;
      idle_ref = tn;
      if (iev) begin
        rep_on = 1'b1;
        press_ref = tn;
      end
    end else if (insets && TICK && (tn - idle_ref) == TO) begin
      st_n = 0;
      rep_on = 1'b0;
    end
    if (!m_deb[1]) rep_on = 1'b0;
    if ((st_n != 0 && st_n != m_state) || ch_n) blink_ref = tn;
    m_blink = (st_n == 0) ? 1'b1 : ((((tn - blink_ref) / BH) % 2) == 0);
    m_debp = m_deb;
    for (int k = 0; k < 2; k++) begin
      if (m_s2[k] == m_deb[k]) m_diff[k] = 0;
      else begin
        m_diff[k] += int'(TICK);
        if (m_diff[k] == DEB) begin
          m_deb[k] = ~m_deb[k];
          m_diff[k] = 0;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = {KEY_INC, KEY_MODE};
    m_state = st_n;
    m_ch = ch_n;
    tick_no = tn;
  endtask

  int tdiv = 0, tb_ticks = 0, ch_cnt = 0;
  bit ch_prev = 1'b0;

  task automatic step();
    TICK = (tdiv == 3);
    @(posedge CP);
    model_step();
    if (TICK) tb_ticks++;
    #1;
    check("state", int'(STATE), m_state);
    check("adjmode", int'(ADJMODE), int'(m_state != 0));
    check("selmode", int'(SELMODE), int'(m_state == 2));
    check("ch", int'(CH), int'(m_ch));
    check("blink", int'(BLINK), int'(m_blink));
    if (CH) begin
      ch_cnt++;
      check("ch_needs_adj", int'(ADJMODE), 1);
      check("ch_consecutive", int'(ch_prev), 0);
    end
    ch_prev = CH;
    tdiv = (tdiv + 1) % 4;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic press(input bit inc, input int hold_t, input int rel_t);
    if (inc) KEY_INC = 1'b1; else KEY_MODE = 1'b1;
    run(4 * hold_t);
    if (inc) KEY_INC = 1'b0; else KEY_MODE = 1'b0;
    run(4 * rel_t);
  endtask

  task automatic wait_state(input int s, input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (int'(STATE) == s) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_state_bound", int'(ok), 1);
  endtask

  task automatic wait_ch(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (CH) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_ch_bound", int'(ok), 1);
  endtask

  int t_entry, t_ch, r;

  initial begin
    RST = 1'b1; KEY_MODE = 1'b0; KEY_INC = 1'b0; TICK = 1'b0;
    run(3);
    check("rst_state", int'(STATE), 0);
    check("rst_blink", int'(BLINK), 1);
    check("rst_ch", int'(CH), 0);
    RST = 1'b0;
    run(40);
    check("idle_run_state", int'(STATE), 0);
    check("idle_run_no_ch", ch_cnt, 0);

    // Three clean MODE presses cycle the full sequence.
    press(1'b0, 4, 4); check("mode1_state", int'(STATE), 1);
    press(1'b0, 4, 4); check("mode2_state", int'(STATE), 2);
    check("mode2_sel", int'(SELMODE), 1);
    press(1'b0, 4, 4); check("mode3_state", int'(STATE), 0);
    check("mode_no_ch", ch_cnt, 0);

    // Bouncy MODE press: only one advance.
    KEY_MODE = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run(1);
      KEY_MODE = ~KEY_MODE;
    end
    KEY_MODE = 1'b1; run(16); KEY_MODE = 1'b0; run(16);
    check("bounce_state", int'(STATE), 1);

    // INC held 15 ticks in SET_MIN: press + repeats at +5,+8,+11,+14.
    ch_cnt = 0;
    press(1'b1, 15, 4);
    check("repeat_pulses", ch_cnt, 5);
    check("repeat_state", int'(STATE), 1);
    run(4 * 25);
    check("timeout_state", int'(STATE), 0);
    check("timeout_blink", int'(BLINK), 1);

    // Idle timeout measured from SET_MIN entry.
    KEY_MODE = 1'b1;
    wait_state(1, 100);
    t_entry = tb_ticks;
    run(16); KEY_MODE = 1'b0;
    wait_state(0, 400);
    check("timeout_ticks", tb_ticks - t_entry, TO);

    // INC press around tick 15 restarts the idle window.
    KEY_MODE = 1'b1;
    wait_state(1, 100);
    t_entry = tb_ticks;
    ch_cnt = 0;
    run(16); KEY_MODE = 1'b0;
    run(4 * 9);
    KEY_INC = 1'b1;
    wait_ch(100);
    t_ch = tb_ticks;
    run(8); KEY_INC = 1'b0;
    wait_state(0, 400);
    check("timeout_after_inc", tb_ticks - t_ch, TO);
    check("timeout_extended", int'((tb_ticks - t_entry) > TO), 1);
    check("inc_single_ch", ch_cnt, 1);

    // INC in RUN is ignored.
    ch_cnt = 0;
    press(1'b1, 4, 4);
    check("run_inc_no_ch", ch_cnt, 0);
    check("run_inc_state", int'(STATE), 0);

    // Simultaneous MODE and INC in SET_HOUR: MODE wins.
    press(1'b0, 4, 4); press(1'b0, 4, 4);
    check("hour_state", int'(STATE), 2);
    ch_cnt = 0;
    KEY_MODE = 1'b1; KEY_INC = 1'b1;
    run(16);
    KEY_MODE = 1'b0; KEY_INC = 1'b0;
    run(16);
    check("simul_state", int'(STATE), 0);
    check("simul_no_ch", ch_cnt, 0);

    // Reset mid-operation aborts to RUN.
    press(1'b0, 4, 4);
    KEY_INC = 1'b1;
    run(10);
    RST = 1'b1; run(1); RST = 1'b0;
    check("midrst_state", int'(STATE), 0);
    check("midrst_ch", int'(CH), 0);
    run(16); KEY_INC = 1'b0; run(16);

    // Random key activity with occasional resets.
    for (int it = 0; it < 150; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        RST = 1'b1; run(int'($urandom_range(1, 2))); RST = 1'b0;
      end else if (r < 15) begin
        repeat (int'($urandom_range(2, 8))) begin
          KEY_MODE = 1'($urandom_range(0, 1));
          KEY_INC  = 1'($urandom_range(0, 1));
          run(1);
        end
      end else begin
        KEY_MODE = ($urandom_range(0, 3) == 0);
        KEY_INC  = ($urandom_range(0, 2) == 0);
        run(int'($urandom_range(4, 100)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Front-panel controller for the digital-clock core. It debounces the two time-setting keys and runs the RUN / SET_MIN / SET_HOUR mode sequence. It drives the core's ADJMODE, SELMODE and CH inputs, generating CH pulses for single presses and for auto-repeat while a key is held. It also returns to RUN after an idle timeout and produces a blink enable for the field being adjusted. It sits between the board keys and the clock core, clocked by the system clock with a 1 kHz tick strobe.

## Interface
- DEB_TICKS, 20: consecutive ticks a synchronized key must hold a new level before the debounced level changes.
- REPEAT_DELAY, 500: ticks INC must be held after its press event before the first auto-repeat pulse.
- REPEAT_PERIOD, 100: ticks between subsequent auto-repeat pulses.
- TIMEOUT_TICKS, 10000: idle ticks in a SET state before forced return to RUN.
- BLINK_HALF, 250: ticks per BLINK half-period.
- CP  in  1  system clock; the block uses only this clock.
- RST  in  1  reset; synchronous, active-high.
- TICK  in  1  1 kHz strobe, high for one CP cycle, synchronous to CP.
- KEY_MODE  in  1  raw mode key, active-high, asynchronous.
- KEY_INC  in  1  raw increment key, active-high, asynchronous.
- ADJMODE  out  1  1 in either SET state.
- SELMODE  out  1  1 in SET_HOUR only; 0 otherwise.
- CH  out  1  one-CP-cycle increment pulse to the selected field.
- BLINK  out  1  display enable for the selected field.
- STATE  out  2  00 RUN, 01 SET_MIN, 10 SET_HOUR; 11 is never driven.

## Operation
- Each raw key passes through a 2-flop synchronizer, then a per-key debounce counter.
- Debounce:
  - The counter advances only on TICK while the synchronized level differs from the debounced level.
  - The counter clears whenever the levels match.
  - The debounced level flips on the tick where the count reaches DEB_TICKS.
- A press event is a 0→1 transition of the debounced level. Each press event lasts one CP cycle.
- FSM transitions on a MODE event: RUN→SET_MIN→SET_HOUR→RUN. There is no other MODE path.
- INC handling:
  - An INC event in SET_MIN or SET_HOUR produces one CH pulse.
  - An INC event in RUN is ignored: no CH, no state change.
- Auto-repeat:
  - While debounced INC stays 1 in a SET state, a repeat counter counts ticks.
  - The first repeat CH occurs at REPEAT_DELAY ticks after the press event, then every REPEAT_PERIOD ticks.
  - INC release, a MODE event or a state change clears the repeat counter and stops repeat.
- Simultaneous MODE and INC events in the same cycle: MODE wins, no CH is issued, and the state advances.
- Timeout:
  - An idle counter counts ticks in SET states.
  - Any MODE event, INC event or repeat pulse clears it.
  - When it reaches TIMEOUT_TICKS, the state becomes RUN and no CH is issued.
  - The idle counter is held at 0 in RUN.
- Blink:
  - In RUN, BLINK=1.
  - In SET states, BLINK toggles every BLINK_HALF ticks.
  - BLINK is forced to 1 and the blink counter cleared on entry to a SET state and on every CH pulse.
- Output decode:
  - ADJMODE = (STATE≠00).
  - SELMODE = (STATE==10).
  - Both are registered. They change in the same cycle as STATE.

## Timing
- Reset (RST=1 at a CP edge): STATE=00, ADJMODE=0, SELMODE=0, CH=0, BLINK=1. Debounced levels are 0, and all counters and synchronizers are 0.
- Reset mid-operation: a SET state aborts to RUN on the next edge, and any pending repeat or CH is cancelled.
- Raw edge to debounced change: 2 CP cycles of synchronization, then DEB_TICKS ticks of stability.
- Press event to outputs: the event is generated in the CP cycle after the debounced level changes. CH and STATE update at the following edge, so CH is high for exactly 1 CP cycle, 1 cycle after the event.
- A key held through reset is not seen as a new press. After reset, the debounced level must first reach 1 from 0.
- CH is never high for two consecutive CP cycles.
- CH is never asserted while ADJMODE=0.

## Test plan
All scenarios use DEB_TICKS=2, REPEAT_DELAY=5, REPEAT_PERIOD=3, TIMEOUT_TICKS=20, BLINK_HALF=4, with TICK every 4 CP cycles.
- Reset, then no keys: STATE=00, ADJMODE=0, SELMODE=0, CH=0, BLINK=1 indefinitely.
- Three clean MODE presses (each held for 4 ticks, released for 4 ticks): STATE goes 01, then 10 (ADJMODE=1, SELMODE=1), then 00. No CH pulses occur.
- Bounce on MODE (toggling every CP cycle for 6 cycles), then a steady 1: exactly one transition RUN→SET_MIN.
- In SET_MIN, INC held for 15 ticks: CH pulses at the press event, then at +5, +8, +11 and +14 ticks, for 5 pulses total. Each is 1 cycle wide and SELMODE=0 throughout.
- INC press in RUN: no CH. In SET_HOUR, MODE and INC debounced on the same cycle: STATE→00 with no CH.
- In SET_MIN with no keys for 20 ticks: STATE→00 and BLINK=1. With an INC press at tick 15, the timeout is instead reached at tick 35.
